reg_file_scoreboard: RTL and testbench

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

---
 rtl/reg_file_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_file_scoreboard.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with post-reset clearing sweep and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy1,
   output logic              busy2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              iss_v,
   input  logic [ADDR_W-1:0] iss_a,
   output logic              ready
);

   localparam int NREG = 2 ** ADDR_W;

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [DATA_W-1:0] regs_q [NREG];

   logic wr_en;

   assign ready = (state_q == S_READY);
   assign wr_en = ready && we && (wa != '0);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == S_CLEAR) begin
         if (&idx_q) begin
            state_d = S_READY;
         end else begin
            idx_d = idx_q + ADDR_W'(1);
         end
      end
   end

   // Clear before set so a same-address issue wins over the write.
   always_comb begin
      busy_d = busy_q;
      if (ready) begin
         if (we) begin
            busy_d[wa] = 1'b0;
         end
         if (iss_v && (iss_a != '0)) begin
            busy_d[iss_a] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLEAR;
         idx_q   <= ADDR_W'(1);
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   // Storage has no reset; contents are zeroed by the sweep instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         regs_q[wa] <= wd;
      end else if (state_q == S_CLEAR) begin
         regs_q[idx_q] <= '0;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ready && (ra1 != '0)) rd1 = regs_q[ra1];
      if (ready && (ra2 != '0)) rd2 = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (ra1 == wa)) rd1 = wd;
      if (wr_en && (ra2 == wa)) rd2 = wd;
`else
`endif
   end

   assign busy1 = busy_q[ra1];
   assign busy2 = busy_q[ra2];

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed and random stimulus for reg_file_scoreboard, checked against
// an array-based reference model of the register file and scoreboard.
module tb_reg_file_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, iss_a = '0;
   logic [31:0] rd1, rd2, wd = '0;
   logic        busy1, busy2, we = 1'b0, iss_v = 1'b0, ready;

   int checks = 0;
   int failures = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   bit [31:0] m_reg [32];
   bit        m_busy [32];
   bit        m_ready;
   int        m_clear_cnt;

   always #5 clk = ~clk;

   reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2),
      .we(we), .wa(wa), .wd(wd),
      .iss_v(iss_v), .iss_a(iss_a), .ready(ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit [31:0] exp_rd(input bit [4:0] ra);
      if (!m_ready || ra == 0) return 32'h0;
      if (BYP && we && wa != 0 && ra == wa) return wd;
      return m_reg[ra];
   endfunction

   task automatic check_outputs();
      chk("ready", {31'b0, ready}, {31'b0, m_ready});
      chk("rd1", rd1, exp_rd(ra1));
      chk("rd2", rd2, exp_rd(ra2));
      chk("busy1", {31'b0, busy1}, {31'b0, m_busy[ra1]});
      chk("busy2", {31'b0, busy2}, {31'b0, m_busy[ra2]});
   endtask

   // Called at a negedge; checks before the posedge, then advances the model.
   task automatic step(input bit we_, input bit [4:0] wa_, input bit [31:0] wd_,
                       input bit iv_, input bit [4:0] ia_,
                       input bit [4:0] r1_, input bit [4:0] r2_);
      we = we_; wa = wa_; wd = wd_;
      iss_v = iv_; iss_a = ia_;
      ra1 = r1_; ra2 = r2_;
      #1 check_outputs();
      @(posedge clk);
      if (m_ready) begin
         if (we_ && wa_ != 0) m_reg[wa_] = wd_;
         if (we_) m_busy[wa_] = 1'b0;
         if (iv_ && ia_ != 0) m_busy[ia_] = 1'b1;
      end else begin
         m_clear_cnt++;
         if (m_clear_cnt == 31) begin
            m_ready = 1'b1;
            foreach (m_reg[i]) m_reg[i] = 32'h0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit [4:0] r1_, input bit [4:0] r2_);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r1_, r2_);
   endtask

   task automatic rand_step(input int addr_hi);
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, addr_hi)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, addr_hi)),
           5'($urandom_range(0, addr_hi)), 5'($urandom_range(0, addr_hi)));
   endtask

   // Called at a negedge; asserts reset, checks immediately, releases next negedge.
   task automatic do_reset(input bit [4:0] r1_, input bit [4:0] r2_);
      ra1 = r1_; ra2 = r2_;
      we = 1'b0; iss_v = 1'b0;
      rst_n = 1'b0;
      m_ready = 1'b0;
      m_clear_cnt = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      #1 check_outputs();
      chk("rst_busy1_zero", {31'b0, busy1}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset(5'd1, 5'd31);
      for (int i = 0; i < 31; i++) rand_step(31);
      chk("ready_after_sweep", {31'b0, ready}, 32'h1);
      idle(5'd5, 5'd31);

      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd4);
      idle(5'd5, 5'd0);
      chk("rd1_deadbeef", rd1, 32'hDEADBEEF);

      step(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd5);
      idle(5'd0, 5'd0);
      chk("r0_busy", {31'b0, busy1}, 32'h0);

      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
      idle(5'd7, 5'd6);
      chk("busy7_set", {31'b0, busy1}, 32'h1);
      step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd7);
      idle(5'd7, 5'd7);
      chk("busy7_clr", {31'b0, busy1}, 32'h0);

      step(1'b1, 5'd9, 32'hA5A5_0009, 1'b1, 5'd9, 5'd9, 5'd8);
      idle(5'd9, 5'd9);
      chk("busy9_set_wins", {31'b0, busy1}, 32'h1);
      chk("reg9_written", rd1, 32'hA5A5_0009);

      for (int i = 0; i < 300; i++) rand_step(i < 150 ? 7 : 31);

      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9);
      do_reset(5'd3, 5'd9);
      for (int i = 0; i < 9; i++) rand_step(31);
      do_reset(5'd10, 5'd3);
      chk("midsweep_ready", {31'b0, ready}, 32'h0);
      for (int i = 0; i < 31; i++) rand_step(31);
      chk("ready_after_resweep", {31'b0, ready}, 32'h1);
      for (int i = 1; i < 32; i += 2) idle(5'(i), 5'(i - 1));

      for (int i = 0; i < 200; i++) rand_step(i < 100 ? 3 : 31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
